// File: rtl/aes_seeded_stimulus.sv
// Seeded AES stimulus generator: single-bit plaintext flips under the seed key, then under the
// inverted key, then the bare seed. Defining AES_STIM_ABORT_EN adds an abort input.
module aes_seeded_stimulus #(
   parameter int KEY_SIZE  = 128,
   parameter int NUM_FLIPS = 128
) (
   input  logic                clock,
   input  logic                reset,
`ifdef AES_STIM_ABORT_EN
   input  logic                abort,
`endif
   input  logic                start,
   input  logic [127:0]        seedPlain,
   input  logic [KEY_SIZE-1:0] seedKey,
   output logic [127:0]        plainData,
   output logic [KEY_SIZE-1:0] inputKey,
   output logic                outValid,
   input  logic                outReady,
   output logic [8:0]          vecIndex,
   output logic                busy,
   output logic                done
);

   typedef enum logic [2:0] {IDLE, FLIP_KEY, FLIP_NOTKEY, FINAL, DONE} state_t;

   localparam logic [8:0] FLIPS       = 9'(NUM_FLIPS);
   localparam logic [8:0] LAST_KEY    = 9'(NUM_FLIPS - 1);
   localparam logic [8:0] LAST_NOTKEY = 9'(2 * NUM_FLIPS - 1);
   localparam logic [8:0] FINAL_IDX   = 9'(2 * NUM_FLIPS);

   state_t                r_state;
   state_t                w_nextState;
   logic [127:0]          r_seedPlain;
   logic [KEY_SIZE-1:0]   r_seedKey;
   logic [127:0]          r_plainData;
   logic [KEY_SIZE-1:0]   r_inputKey;
   logic [8:0]            r_vecIndex;

   logic                  w_abort;
   logic                  w_busy;
   logic                  w_load;
   logic                  w_advance;
   logic [8:0]            w_nextIdx;
   logic [6:0]            w_bitPos;
   logic [127:0]          w_flipMask;
   logic [127:0]          w_nextPlain;
   logic [KEY_SIZE-1:0]   w_nextKey;

`ifdef AES_STIM_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_busy      = 1'b0;
      w_load      = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_nextState = FLIP_KEY;
            end
         end
         FLIP_KEY: begin
            w_busy = 1'b1;
            if (outReady && r_vecIndex == LAST_KEY) w_nextState = FLIP_NOTKEY;
         end
         FLIP_NOTKEY: begin
            w_busy = 1'b1;
            if (outReady && r_vecIndex == LAST_NOTKEY) w_nextState = FINAL;
         end
         FINAL: begin
            w_busy = 1'b1;
            if (outReady) w_nextState = DONE;
         end
         DONE: begin
            done        = 1'b1;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
      // abort wins over any transfer happening in the same cycle
      if (w_busy && w_abort) w_nextState = IDLE;
      w_advance = w_busy && outReady && !w_abort;
   end

   // Next vector is computed from the index it will carry, so phase boundaries need no bubble
   assign w_nextIdx   = r_vecIndex + 9'd1;
   assign w_bitPos    = (w_nextIdx < FLIPS) ? w_nextIdx[6:0] : 7'(w_nextIdx - FLIPS);
   assign w_flipMask  = 128'(1) << w_bitPos;
   assign w_nextPlain = (w_nextIdx < FINAL_IDX) ? (r_seedPlain ^ w_flipMask) : r_seedPlain;
   assign w_nextKey   = (w_nextIdx >= FLIPS && w_nextIdx < FINAL_IDX) ? ~r_seedKey : r_seedKey;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_seedPlain <= '0;
         r_seedKey   <= '0;
         r_plainData <= '0;
         r_inputKey  <= '0;
         r_vecIndex  <= '0;
      end else if (w_load) begin
         r_seedPlain <= seedPlain;
         r_seedKey   <= seedKey;
         r_plainData <= seedPlain ^ 128'(1);
         r_inputKey  <= seedKey;
         r_vecIndex  <= '0;
      end else if (w_advance) begin
         r_vecIndex <= w_nextIdx;
         // the FINAL vector stays on the outputs after the sequence ends
         if (r_state != FINAL) begin
            r_plainData <= w_nextPlain;
            r_inputKey  <= w_nextKey;
         end
      end
   end

   assign plainData = r_plainData;
   assign inputKey  = r_inputKey;
   assign vecIndex  = r_vecIndex;
   assign outValid  = w_busy;
   assign busy      = w_busy;

endmodule

// File: tb/tb_aes_seeded_stimulus.sv
// Testbench for aes_seeded_stimulus: default instance plus a NUM_FLIPS=4 / KEY_SIZE=256 instance.
// Exercises the abort port when AES_STIM_ABORT_EN is defined.
module tb_aes_seeded_stimulus;

   localparam int NF = 128;
   localparam int KS = 128;
   localparam int SNF = 4;
   localparam int SKS = 256;

   logic            clock;
   logic            reset;
   logic            start;
   logic [127:0]    seedPlain;
   logic [KS-1:0]   seedKey;
   logic [127:0]    plainData;
   logic [KS-1:0]   inputKey;
   logic            outValid;
   logic            outReady;
   logic [8:0]      vecIndex;
   logic            busy;
   logic            done;
   logic            abort;

   logic            sStart;
   logic [127:0]    sSeedPlain;
   logic [SKS-1:0]  sSeedKey;
   logic [127:0]    sPlainData;
   logic [SKS-1:0]  sInputKey;
   logic            sOutValid;
   logic            sOutReady;
   logic [8:0]      sVecIndex;
   logic            sBusy;
   logic            sDone;
   logic            sAbort;

   int errors = 0;
   int checks = 0;

   aes_seeded_stimulus #(.KEY_SIZE(KS), .NUM_FLIPS(NF)) dut (
      .clock(clock), .reset(reset),
`ifdef AES_STIM_ABORT_EN
      .abort(abort),
`endif
      .start(start), .seedPlain(seedPlain), .seedKey(seedKey),
      .plainData(plainData), .inputKey(inputKey), .outValid(outValid),
      .outReady(outReady), .vecIndex(vecIndex), .busy(busy), .done(done)
   );

   aes_seeded_stimulus #(.KEY_SIZE(SKS), .NUM_FLIPS(SNF)) dutSmall (
      .clock(clock), .reset(reset),
`ifdef AES_STIM_ABORT_EN
      .abort(sAbort),
`endif
      .start(sStart), .seedPlain(sSeedPlain), .seedKey(sSeedKey),
      .plainData(sPlainData), .inputKey(sInputKey), .outValid(sOutValid),
      .outReady(sOutReady), .vecIndex(sVecIndex), .busy(sBusy), .done(sDone)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model: vector idx of an n-flip sequence, straight from the phase rules
   function automatic logic [255:0] expPlain(input logic [127:0] seed, input int idx, input int n);
      logic [127:0] mask;
      mask = '0;
      if (idx < n) mask[idx] = 1'b1;
      else if (idx < 2 * n) mask[idx - n] = 1'b1;
      return {128'd0, seed ^ mask};
   endfunction

   function automatic logic [255:0] expKey(input logic [255:0] k, input int idx, input int n, input int w);
      logic [255:0] r;
      r = (idx >= n && idx < 2 * n) ? ~k : k;
      for (int b = w; b < 256; b++) r[b] = 1'b0;
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic runMain(input logic [127:0] sp, input logic [KS-1:0] sk, input int stallAt,
                          input int startAt, input int randFrom, input int resetAt);
      int expIdx;
      int stall;
      int cycles;
      seedPlain = sp;
      seedKey   = sk;
      start     = 1'b1;
      outReady  = 1'b1;
      applyStimulus();
      start     = 1'b0;
      seedPlain = ~sp;
      seedKey   = ~sk;
      expIdx = 0;
      stall  = 0;
      cycles = 0;
      while (expIdx <= 2 * NF && cycles < 3000) begin
         checkOutput("outValid", outValid, 1);
         checkOutput("busy", busy, 1);
         checkOutput("doneLow", done, 0);
         checkOutput("vecIndex", vecIndex, expIdx);
         checkOutput("plainData", plainData, expPlain(sp, expIdx, NF));
         checkOutput("inputKey", inputKey, expKey(sk, expIdx, NF, KS));
         if (expIdx == resetAt) begin
            reset = 1'b1;
            #1;
            checkOutput("rstValid", outValid, 0);
            checkOutput("rstBusy", busy, 0);
            checkOutput("rstDone", done, 0);
            checkOutput("rstIndex", vecIndex, 0);
            checkOutput("rstPlain", plainData, 0);
            checkOutput("rstKey", inputKey, 0);
            applyStimulus();
            checkOutput("rstNoDone", done, 0);
            reset = 1'b0;
            return;
         end
         outReady = 1'b1;
         if (expIdx == stallAt && stall < 5) begin
            outReady = 1'b0;
            stall++;
         end else if (randFrom >= 0 && expIdx >= randFrom) begin
            outReady = 1'($urandom_range(0, 1));
         end
         if (expIdx == startAt) begin
            start     = 1'b1;
            seedPlain = '1;
         end
         applyStimulus();
         start = 1'b0;
         if (outReady) expIdx++;
         cycles++;
      end
      checkOutput("cycleBudget", cycles < 3000, 1);
      checkOutput("doneHigh", done, 1);
      checkOutput("doneValid", outValid, 0);
      checkOutput("doneBusy", busy, 0);
      checkOutput("holdPlain", plainData, {128'd0, sp});
      applyStimulus();
      checkOutput("donePulse", done, 0);
      checkOutput("idleValid", outValid, 0);
      checkOutput("idleBusy", busy, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; outReady = 1'b0; seedPlain = '0; seedKey = '0; abort = 1'b0;
      sStart = 1'b0; sOutReady = 1'b0; sSeedPlain = '0; sSeedKey = '0; sAbort = 1'b0;
      #2;
      checkOutput("resetValid", outValid, 0);
      checkOutput("resetIndex", vecIndex, 0);
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetDone", done, 0);
      checkOutput("resetPlain", plainData, 0);
      checkOutput("resetKey", inputKey, 0);

      $display("[TB] zero seed, full-rate sequence");
      runMain('0, '0, -1, -1, -1, -1);

      $display("[TB] stall at 127, start pulse at 50");
      runMain(rand128(), rand128(), 127, 50, -1, -1);

      $display("[TB] random outReady");
      runMain(rand128(), rand128(), -1, -1, 140, -1);

      $display("[TB] reset at 200, then restart");
      runMain(rand128(), rand128(), -1, -1, -1, 200);
      runMain(rand128(), rand128(), -1, -1, 20, -1);

`ifdef AES_STIM_ABORT_EN
      begin
         logic [127:0] ap;
         logic [KS-1:0] ak;
         $display("[TB] abort at 10");
         ap = rand128();
         ak = rand128();
         seedPlain = ap; seedKey = ak; start = 1'b1; outReady = 1'b1;
         applyStimulus();
         start = 1'b0;
         for (int i = 0; i <= 10; i++) begin
            checkOutput("abortIndex", vecIndex, i);
            checkOutput("abortPlain", plainData, expPlain(ap, i, NF));
            if (i == 10) begin
               abort = 1'b1;
               start = 1'b1;
            end
            applyStimulus();
         end
         abort = 1'b0;
         start = 1'b0;
         checkOutput("abortValid", outValid, 0);
         checkOutput("abortBusy", busy, 0);
         checkOutput("abortDone", done, 0);
         applyStimulus();
         checkOutput("abortNoDone", done, 0);
         checkOutput("abortIdle", outValid, 0);
      end
`endif

      $display("[TB] NUM_FLIPS=4 KEY_SIZE=256");
      begin
         logic [127:0] sp;
         logic [255:0] sk;
         sp = rand128();
         sk = {rand128(), rand128()};
         sSeedPlain = sp; sSeedKey = sk; sStart = 1'b1; sOutReady = 1'b1;
         applyStimulus();
         sStart = 1'b0;
         for (int i = 0; i <= 2 * SNF; i++) begin
            checkOutput("sValid", sOutValid, 1);
            checkOutput("sIndex", sVecIndex, i);
            checkOutput("sPlain", sPlainData, expPlain(sp, i, SNF));
            checkOutput("sKey", sInputKey, expKey(sk, i, SNF, SKS));
            applyStimulus();
         end
         checkOutput("sDone", sDone, 1);
         checkOutput("sDoneValid", sOutValid, 0);
         applyStimulus();
         checkOutput("sDonePulse", sDone, 0);
         checkOutput("sIdleBusy", sBusy, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
